// File: rtl/mmio_axi4_rd_splitter.sv
// Splits AXI4 read bursts from the core MMIO port into single-beat reads for
// len=0-only peripherals; one burst in flight, one downstream beat outstanding.
module mmio_axi4_rd_splitter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    // upstream read address
    input  logic              s_ar_valid,
    output logic              s_ar_ready,
    input  logic [ID_W-1:0]   s_ar_id,
    input  logic [ADDR_W-1:0] s_ar_addr,
    input  logic [7:0]        s_ar_len,
    input  logic [2:0]        s_ar_size,
    input  logic [1:0]        s_ar_burst,
    // upstream read data
    output logic              s_r_valid,
    input  logic              s_r_ready,
    output logic [ID_W-1:0]   s_r_id,
    output logic [DATA_W-1:0] s_r_data,
    output logic [1:0]        s_r_resp,
    output logic              s_r_last,
    // downstream single-beat read address
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [ADDR_W-1:0] m_ar_addr,
    // downstream read data
    input  logic              m_r_valid,
    output logic              m_r_ready,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        MD_FIXED,
        MD_INCR,
        MD_WRAP
    } mode_t;

    state_t            r_state;
    state_t            w_state_next;
    mode_t             r_mode;
    mode_t             w_mode_in;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [7:0]        r_beat_cnt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_mask;
    logic [ADDR_W-1:0] r_bytes;

    logic [2:0]        w_size_eff;
    logic [ADDR_W-1:0] w_bytes_in;
    logic [ADDR_W-1:0] w_mask_in;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_wrap_ok;
    logic              w_accept;
    logic              w_beat_done;
    logic              w_last;

    // Beat size never exceeds the bus width; the wrap container mask is
    // (len+1)*bytes-1 and is only honoured for 2/4/8/16-beat bursts.
    assign w_size_eff = (s_ar_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : s_ar_size;
    assign w_bytes_in = ADDR_W'(1) << w_size_eff;
    assign w_mask_in  = ((ADDR_W'(s_ar_len) + ADDR_W'(1)) << w_size_eff) - ADDR_W'(1);
    assign w_wrap_ok  = (s_ar_len == 8'd1) || (s_ar_len == 8'd3) ||
                        (s_ar_len == 8'd7) || (s_ar_len == 8'd15);
    assign w_last     = (r_beat_cnt == r_len);

    always_comb begin
        case (s_ar_burst)
            2'b00:   w_mode_in = MD_FIXED;
            2'b10:   w_mode_in = w_wrap_ok ? MD_WRAP : MD_INCR;
            default: w_mode_in = MD_INCR;
        endcase
    end

    always_comb begin
        case (r_mode)
            MD_FIXED: w_next_addr = r_cur_addr;
            MD_WRAP:  w_next_addr = r_base | ((r_cur_addr + r_bytes) & r_mask);
            default:  w_next_addr = r_cur_addr + r_bytes;
        endcase
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no
        // branch can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_beat_done  = 1'b0;
        s_ar_ready   = 1'b0;
        m_ar_valid   = 1'b0;
        m_ar_addr    = '0;
        s_r_valid    = 1'b0;
        m_r_ready    = 1'b0;
        s_r_id       = '0;
        s_r_data     = '0;
        s_r_resp     = '0;
        s_r_last     = 1'b0;
        // Outputs are forced quiet for the whole time reset is held, including
        // the cycle before the synchronous reset takes effect.
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    s_ar_ready = 1'b1;
                    if (s_ar_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_ar_valid = 1'b1;
                    m_ar_addr  = r_cur_addr;
                    if (m_ar_ready) begin
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    s_r_valid = m_r_valid;
                    m_r_ready = s_r_ready;
                    s_r_data  = m_r_data;
                    s_r_resp  = m_r_resp;
                    s_r_id    = r_id;
                    s_r_last  = w_last;
                    if (m_r_valid && s_r_ready) begin
                        w_beat_done  = 1'b1;
                        w_state_next = w_last ? ST_IDLE : ST_ISSUE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mode     <= MD_FIXED;
            r_id       <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_cur_addr <= '0;
            r_base     <= '0;
            r_mask     <= '0;
            r_bytes    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_id       <= s_ar_id;
                r_len      <= s_ar_len;
                r_beat_cnt <= '0;
                r_cur_addr <= s_ar_addr;
                r_base     <= s_ar_addr & ~w_mask_in;
                r_mask     <= w_mask_in;
                r_bytes    <= w_bytes_in;
                r_mode     <= w_mode_in;
            end else if (w_beat_done && !w_last) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                r_cur_addr <= w_next_addr;
            end
        end
    end

endmodule

// File: tb/tb_mmio_axi4_rd_splitter.sv
// Randomized bench for mmio_axi4_rd_splitter: transaction-level model of the
// expected beat addresses and upstream/downstream handshakes, checked every cycle.
module tb_mmio_axi4_rd_splitter;

    logic        clock = 1'b0;
    logic        reset;
    logic        s_ar_valid;
    logic        s_ar_ready;
    logic [3:0]  s_ar_id;
    logic [31:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [2:0]  s_ar_size;
    logic [1:0]  s_ar_burst;
    logic        s_r_valid;
    logic        s_r_ready;
    logic [3:0]  s_r_id;
    logic [63:0] s_r_data;
    logic [1:0]  s_r_resp;
    logic        s_r_last;
    logic        m_ar_valid;
    logic        m_ar_ready;
    logic [31:0] m_ar_addr;
    logic        m_r_valid;
    logic        m_r_ready;
    logic [63:0] m_r_data;
    logic [1:0]  m_r_resp;

    mmio_axi4_rd_splitter #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_ar_id    (s_ar_id),
        .s_ar_addr  (s_ar_addr),
        .s_ar_len   (s_ar_len),
        .s_ar_size  (s_ar_size),
        .s_ar_burst (s_ar_burst),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .s_r_id     (s_r_id),
        .s_r_data   (s_r_data),
        .s_r_resp   (s_r_resp),
        .s_r_last   (s_r_last),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_ar_addr  (m_ar_addr),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .m_r_data   (m_r_data),
        .m_r_resp   (m_r_resp)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } burst_t;

    localparam int BUDGET   = 60000;
    localparam int N_RANDOM = 150;

    int n_checks = 0;
    int n_errors = 0;
    int cycles   = 0;
    int bursts_done = 0;
    int hold_cnt = 0;

    burst_t      burst_q[$];
    logic [31:0] addr_q[$];

    // Transaction-level model state
    bit          busy = 0;
    bit          outst = 0;
    bit          ar_pending = 0;
    bit          slv_req = 0;
    bit          slv_driving = 0;
    logic [3:0]  cur_id = '0;
    logic [7:0]  cur_len = '0;
    int          beat = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Next beat address from AXI burst rules, in plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] start,
                                               input logic [7:0] len, input logic [2:0] size,
                                               input logic [1:0] burst);
        longint unsigned sz, bytes, beats, span, base, c, s;
        sz    = (size > 3) ? 3 : size;
        bytes = 64'd1 << sz;
        beats = 64'(len) + 1;
        c     = {32'b0, cur};
        s     = {32'b0, start};
        if (burst == 2'b00) return cur;
        if (burst == 2'b10 && (beats == 2 || beats == 4 || beats == 8 || beats == 16)) begin
            span = beats * bytes;
            base = s - (s % span);
            return 32'(base + ((c + bytes - base) % span));
        end
        return 32'((c + bytes) % 64'h1_0000_0000);
    endfunction

    // Per-cycle compare against the model, then advance the model by the
    // handshakes that the coming rising edge will complete.
    logic        e_ar_ready, e_m_ar_valid, e_in_wait;
    logic [31:0] e_addr;
    always @(negedge clock) begin
        e_ar_ready   = !reset && !busy;
        e_m_ar_valid = !reset && busy && !outst;
        e_in_wait    = !reset && busy && outst;
        e_addr       = (e_m_ar_valid && addr_q.size() > 0) ? addr_q[0] : 32'h0;
        if (e_m_ar_valid && addr_q.size() == 0) check("addr_queue_underflow", 1, 0);
        check("s_ar_ready", s_ar_ready, e_ar_ready);
        check("m_ar_valid", m_ar_valid, e_m_ar_valid);
        check("m_ar_addr",  m_ar_addr,  e_addr);
        check("s_r_valid",  s_r_valid,  e_in_wait ? m_r_valid : 1'b0);
        check("m_r_ready",  m_r_ready,  e_in_wait ? s_r_ready : 1'b0);
        check("s_r_data",   s_r_data,   e_in_wait ? m_r_data : 64'h0);
        check("s_r_resp",   s_r_resp,   e_in_wait ? m_r_resp : 2'b00);
        check("s_r_id",     s_r_id,     e_in_wait ? cur_id : 4'h0);
        check("s_r_last",   s_r_last,   e_in_wait ? (beat == int'(cur_len)) : 1'b0);
        if (reset) begin
            busy = 0;
            outst = 0;
            addr_q.delete();
            slv_req = 0;
            ar_pending = 0;
        end else begin
            if (e_ar_ready && s_ar_valid) begin
                logic [31:0] a;
                busy = 1;
                cur_id = s_ar_id;
                cur_len = s_ar_len;
                beat = 0;
                ar_pending = 0;
                addr_q.delete();
                a = s_ar_addr;
                for (int i = 0; i <= int'(s_ar_len); i++) begin
                    addr_q.push_back(a);
                    a = model_next(a, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst);
                end
            end
            if (e_m_ar_valid && m_ar_ready) begin
                outst = 1;
                slv_req = 1;
                void'(addr_q.pop_front());
            end
            if (e_in_wait && m_r_valid && s_r_ready) begin
                outst = 0;
                slv_req = 0;
                if (beat == int'(cur_len)) begin
                    busy = 0;
                    bursts_done++;
                end else begin
                    beat++;
                end
            end
        end
    end

    // One cycle of upstream master, downstream slave and R-ready behaviour.
    task automatic drive_cycle();
        burst_t b;
        if (reset) begin
            s_ar_valid  = 0;
            m_ar_ready  = 0;
            m_r_valid   = 0;
            s_r_ready   = 0;
            slv_driving = 0;
        end else begin
            if (!ar_pending) begin
                s_ar_valid = 0;
                if (burst_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    b = burst_q.pop_front();
                    s_ar_id    = b.id;
                    s_ar_addr  = b.addr;
                    s_ar_len   = b.len;
                    s_ar_size  = b.size;
                    s_ar_burst = b.burst;
                    s_ar_valid = 1;
                    ar_pending = 1;
                end
            end
            m_ar_ready = ($urandom_range(0, 2) != 0);
            if (slv_req) begin
                if (!slv_driving) begin
                    if ($urandom_range(0, 1) == 1) begin
                        slv_driving = 1;
                        m_r_valid = 1;
                        m_r_data  = {$urandom, $urandom};
                        m_r_resp  = 2'($urandom_range(0, 3));
                    end else begin
                        m_r_valid = 0;
                    end
                end
            end else begin
                slv_driving = 0;
                m_r_valid = ($urandom_range(0, 7) == 0);
                m_r_data  = {$urandom, $urandom};
                m_r_resp  = 2'($urandom_range(0, 3));
            end
            if (hold_cnt > 0) begin
                s_r_ready = 0;
                hold_cnt--;
            end else if ($urandom_range(0, 15) == 0) begin
                hold_cnt = 4;
                s_r_ready = 0;
            end else begin
                s_r_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clock);
        #1;
        cycles++;
    endtask

    function automatic burst_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        burst_t b;
        b.id = id; b.addr = addr; b.len = len; b.size = size; b.burst = burst;
        return b;
    endfunction

    int target;

    initial begin
        reset = 1;
        s_ar_valid = 0; s_ar_id = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0;
        s_r_ready = 0; m_ar_ready = 0; m_r_valid = 0; m_r_data = '0; m_r_resp = '0;

        // Hand-computed pins on the address model
        check("pin_wrap_0x1018", model_next(32'h1018, 32'h1018, 8'd3, 3'd3, 2'b10), 32'h1000);
        check("pin_wrap_0x1008", model_next(32'h1008, 32'h1018, 8'd3, 3'd3, 2'b10), 32'h1010);
        check("pin_wrap_0x1010", model_next(32'h1010, 32'h1018, 8'd3, 3'd3, 2'b10), 32'h1018);
        check("pin_incr_rollover", model_next(32'hFFFF_FFF8, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01), 32'h0);
        check("pin_incr_size2", model_next(32'h100C, 32'h1004, 8'd3, 3'd2, 2'b01), 32'h1010);
        check("pin_fixed", model_next(32'h2000, 32'h2000, 8'd2, 3'd3, 2'b00), 32'h2000);
        check("pin_size_clamp", model_next(32'h100, 32'h100, 8'd0, 3'd7, 2'b01), 32'h108);
        check("pin_wrap_len2_incr", model_next(32'h1010, 32'h1010, 8'd2, 3'd3, 2'b10), 32'h1018);
        check("pin_reserved_incr", model_next(32'h1000, 32'h1000, 8'd3, 3'd1, 2'b11), 32'h1002);

        burst_q.push_back(mk(4'd5, 32'h6000_0000, 8'd0, 3'd3, 2'b01));
        burst_q.push_back(mk(4'd1, 32'h0000_1004, 8'd3, 3'd2, 2'b01));
        burst_q.push_back(mk(4'd2, 32'h0000_1018, 8'd3, 3'd3, 2'b10));
        burst_q.push_back(mk(4'd3, 32'h0000_2000, 8'd2, 3'd3, 2'b00));
        burst_q.push_back(mk(4'd4, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01));
        burst_q.push_back(mk(4'd6, 32'h0000_3000, 8'd3, 3'd3, 2'b01));
        for (int i = 0; i < N_RANDOM; i++) begin
            logic [7:0] l;
            l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 15));
            burst_q.push_back(mk(4'($urandom_range(0, 15)), $urandom, l,
                                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))));
        end
        target = burst_q.size();

        repeat (3) @(posedge clock);
        #1;
        reset = 0;

        while (bursts_done < target && cycles < BUDGET) drive_cycle();
        check("bursts_main", bursts_done, target);

        // Reset in the WAIT phase of beat 2 of an 8-beat burst
        burst_q.push_back(mk(4'd7, 32'h0000_5000, 8'd7, 3'd3, 2'b01));
        while (!(busy && outst && beat == 1 && cur_len == 8'd7) && cycles < BUDGET) drive_cycle();
        check("rst_reached_beat2", beat, 1);
        reset = 1;
        drive_cycle();
        drive_cycle();
        reset = 0;
        @(negedge clock);
        check("rst_ar_ready_after", s_ar_ready, 1'b1);
        @(posedge clock);
        #1;

        target = bursts_done + 1;
        burst_q.delete();
        burst_q.push_back(mk(4'd9, 32'h0000_4000, 8'd3, 3'd3, 2'b10));
        while (bursts_done < target && cycles < BUDGET) drive_cycle();
        check("burst_after_reset", bursts_done, target);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_axi4_rd_splitter.md
Name: mmio_axi4_rd_splitter

Overview:
- Converts AXI4 read bursts from the core's MMIO master port into a sequence of single-beat AXI4 reads.
- Sits between the core MMIO read channels and the MMIO slave port, whose peripherals (UART etc.) accept only len=0 transfers.
- Keeps one burst in flight and one downstream beat outstanding at a time.
- Preserves ID and per-beat response; regenerates RLAST.

Parameters:
ADDR_W, 32, address width both sides
DATA_W, 64, data width both sides (bytes per beat = DATA_W/8)
ID_W, 4, upstream AXI ID width

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
s_ar_valid  in  1  upstream read address valid
s_ar_ready  out  1  upstream read address ready
s_ar_id  in  ID_W  burst ID
s_ar_addr  in  ADDR_W  burst start address
s_ar_len  in  8  beats minus one
s_ar_size  in  3  log2 bytes per beat
s_ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_r_valid  out  1  upstream read data valid
s_r_ready  in  1  upstream read data ready
s_r_id  out  ID_W  echoed burst ID
s_r_data  out  DATA_W  beat data
s_r_resp  out  2  beat response
s_r_last  out  1  final beat of burst
m_ar_valid  out  1  downstream single-beat address valid
m_ar_ready  in  1  downstream address ready
m_ar_addr  out  ADDR_W  downstream beat address
m_r_valid  in  1  downstream data valid
m_r_ready  out  1  downstream data ready
m_r_data  in  DATA_W  downstream data
m_r_resp  in  2  downstream response

Behaviour:
- Reset: state IDLE; all registers clear; s_ar_ready=0, s_r_valid=0, m_ar_valid=0, m_r_ready=0; s_r_id/data/resp/last=0. s_ar_ready goes 1 on the first cycle after reset deasserts.
- FSM states:
  - IDLE: s_ar_ready=1, everything else 0. On s_ar_valid&s_ar_ready, latch id, addr, len, size, burst, set beat_cnt=0, go to ISSUE.
  - ISSUE: m_ar_valid=1, m_ar_addr=cur_addr, held stable until m_ar_ready. On handshake go to WAIT.
  - WAIT: combinational pass-through. s_r_valid=m_r_valid, m_r_ready=s_r_ready, s_r_data=m_r_data, s_r_resp=m_r_resp, s_r_id=latched id, s_r_last=(beat_cnt==len). On the R handshake: if last, go to IDLE; else beat_cnt+1, cur_addr=next_addr, go to ISSUE.
- Latency: m_ar_valid asserts the cycle after s_ar acceptance and the cycle after each non-last R handshake. Minimum 2 cycles per beat.
- Outside WAIT, s_r_valid=0 and m_r_ready=0. A stray m_r_valid in IDLE/ISSUE is ignored (not consumed).
- Address generation (bytes = 1<<size_eff; size_eff = min(size, log2(DATA_W/8))):
  - FIXED: next_addr = cur_addr.
  - INCR: next_addr = cur_addr + bytes, modulo 2^ADDR_W. The 4 KB rule is not checked.
  - WRAP: container = (len+1)*bytes, aligned down from the start address. next_addr = base | ((cur_addr + bytes) & (container-1)). Only len+1 in {2,4,8,16} is legal; other lens use INCR rules.
  - burst=11 (reserved): treated as INCR.
- Responses: every beat's m_r_resp is passed unchanged. SLVERR/DECERR does not abort the burst; exactly len+1 beats are always returned.
- Backpressure: while s_r_ready=0 in WAIT, m_r_ready=0 and no new address is issued.
- Reset mid-burst: immediate return to IDLE, in-flight burst dropped. The downstream slave shares this reset.

Test Plan:
- INCR len=0 size=3 addr 0x6000_0000 id=5 -> one m_ar at 0x6000_0000; s_r_last=1, s_r_id=5, data matches; s_ar_ready back to 1 the next cycle.
- INCR len=3 size=2 addr 0x1004 -> m_ar 0x1004, 0x1008, 0x100C, 0x1010; s_r_last only on beat 4.
- WRAP len=3 size=3 addr 0x1018 -> m_ar 0x1018, 0x1000, 0x1008, 0x1010. FIXED len=2 addr 0x2000 -> three reads at 0x2000.
- INCR len=1 size=3 addr 0xFFFF_FFF8 -> m_ar 0xFFFF_FFF8 then 0x0000_0000.
- len=3 with s_r_ready low 5 cycles on beat 2, and m_r_resp=10 on beat 2 -> m_r_ready low throughout, data stable, no AR issued; SLVERR passed through, beats 3-4 still issued.
- reset asserted in WAIT of beat 2 of a len=7 burst -> next cycle all outputs 0; a new burst after reset completes normally.
